// File: rtl/tetris_pkg.sv
//------------------------------------------------------------------------------
// Module   : tetris_pkg
// Brief    : Shared encodings and board geometry for the game controller and
//            the datapath.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package tetris_pkg;

    localparam int ROWS    = 8;
    localparam int ROW_W   = 4;
    localparam int BOARD_W = ROWS * ROW_W;
    localparam int CNT_W   = 4;
    localparam int SCORE_W = 16;

    localparam logic [2:0] ST_GEN      = 3'd0;
    localparam logic [2:0] ST_MOVE     = 3'd1;
    localparam logic [2:0] ST_LAND     = 3'd2;
    localparam logic [2:0] ST_CLEAR    = 3'd3;
    localparam logic [2:0] ST_NEWBOARD = 3'd4;
    localparam logic [2:0] ST_GAMEOVER = 3'd5;

    localparam logic [1:0] MV_LEFT   = 2'd0;
    localparam logic [1:0] MV_RIGHT  = 2'd1;
    localparam logic [1:0] MV_ROTATE = 2'd2;
    localparam logic [1:0] MV_NONE   = 2'd3;

    function automatic logic [SCORE_W-1:0] score_add_sat(
        input logic [SCORE_W-1:0] a,
        input logic [CNT_W-1:0]   b
    );
        logic [SCORE_W:0] s;
        s = {1'b0, a} + {{(SCORE_W+1-CNT_W){1'b0}}, b};
        return s[SCORE_W] ? {SCORE_W{1'b1}} : s[SCORE_W-1:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/row_full_count.sv
//------------------------------------------------------------------------------
// Module   : row_full_count
// Brief    : Combinational count of completely filled board rows.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module row_full_count
    import tetris_pkg::*;
(
    input  logic [BOARD_W-1:0] i_board,
    output logic               o_full_any,
    output logic [CNT_W-1:0]   o_full_cnt
);

    always_comb begin
        o_full_cnt = '0;
        for (int k = 0; k < ROWS; k++) begin
            if (i_board[k*ROW_W +: ROW_W] == {ROW_W{1'b1}}) begin
                o_full_cnt = o_full_cnt + 1'b1;
            end
        end
    end

    assign o_full_any = (o_full_cnt != '0);

endmodule

`default_nettype wire

// File: rtl/game_ctrl.sv
//------------------------------------------------------------------------------
// Module   : game_ctrl
// Brief    : Falling-block game sequencer: spawn, move/gravity, land, clear.
//            Optional macro GAME_CTRL_SCORE_EN enables the row-clear score.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module game_ctrl
    import tetris_pkg::*;
#(
    parameter int DROP_TICKS   = 8,
    parameter int CLEAR_CYCLES = 2
) (
    input  logic               clka,
    input  logic               restart,
    input  logic               start,
    input  logic               btn_left,
    input  logic               btn_right,
    input  logic               btn_rotate,
    input  logic               touched,
    input  logic               error,
    input  logic [BOARD_W-1:0] board_in,
    output logic [2:0]         state,
    output logic [1:0]         move,
    output logic               drop,
    output logic               load_piece,
    output logic               clear_en,
    output logic [SCORE_W-1:0] score
);

    localparam logic [7:0]       c_drop_last = 8'(DROP_TICKS - 1);
    localparam logic [CNT_W-1:0] c_clr_last  = CNT_W'(CLEAR_CYCLES - 1);

    logic [2:0]       r_state,    w_state_nxt;
    logic [1:0]       r_move,     w_move_nxt;
    logic             r_drop,     w_drop_nxt;
    logic             r_load,     w_load_nxt;
    logic             r_clear_en, w_clear_en_nxt;
    logic [2:0]       r_pend,     w_pend_nxt;
    logic [7:0]       r_drop_cnt, w_drop_cnt_nxt;
    logic [CNT_W-1:0] r_clr_cnt,  w_clr_cnt_nxt;

    logic [2:0]       w_btn, w_req, w_sel;
    logic [1:0]       w_sel_mv;
    logic             w_stay_move;
    logic             w_top_busy;
    logic             w_full_any;
    logic [CNT_W-1:0] w_full_cnt;

    row_full_count u_row_full_count (
        .i_board    (board_in),
        .o_full_any (w_full_any),
        .o_full_cnt (w_full_cnt)
    );

    assign w_top_busy = |board_in[BOARD_W-1 -: ROW_W];
    // Bit position equals the move code so the pending vector indexes directly.
    assign w_btn      = {btn_rotate, btn_right, btn_left};

    always_ff @(posedge clka or negedge restart) begin
        if (!restart) begin
            r_state    <= ST_NEWBOARD;
            r_move     <= MV_NONE;
            r_drop     <= 1'b0;
            r_load     <= 1'b0;
            r_clear_en <= 1'b0;
            r_pend     <= '0;
            r_drop_cnt <= '0;
            r_clr_cnt  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_move     <= w_move_nxt;
            r_drop     <= w_drop_nxt;
            r_load     <= w_load_nxt;
            r_clear_en <= w_clear_en_nxt;
            r_pend     <= w_pend_nxt;
            r_drop_cnt <= w_drop_cnt_nxt;
            r_clr_cnt  <= w_clr_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_NEWBOARD: w_state_nxt = ST_GEN;
            ST_GEN:      w_state_nxt = w_top_busy ? ST_GAMEOVER : ST_MOVE;
            ST_MOVE:     w_state_nxt = touched ? ST_LAND : ST_MOVE;
            ST_LAND:     w_state_nxt = w_full_any ? ST_CLEAR : ST_GEN;
            ST_CLEAR:    w_state_nxt = (r_clr_cnt == c_clr_last) ? ST_GEN : ST_CLEAR;
            ST_GAMEOVER: w_state_nxt = start ? ST_NEWBOARD : ST_GAMEOVER;
            default:     w_state_nxt = ST_NEWBOARD;
        endcase
        if (error && (r_state != ST_GAMEOVER)) begin
            w_state_nxt = ST_GAMEOVER;
        end

        w_stay_move = (r_state == ST_MOVE) && (w_state_nxt == ST_MOVE);

        w_req    = r_pend | w_btn;
        w_sel    = 3'b000;
        w_sel_mv = MV_NONE;
        if (w_req[MV_ROTATE]) begin
            w_sel    = 3'b100;
            w_sel_mv = MV_ROTATE;
        end else if (w_req[MV_LEFT]) begin
            w_sel    = 3'b001;
            w_sel_mv = MV_LEFT;
        end else if (w_req[MV_RIGHT]) begin
            w_sel    = 3'b010;
            w_sel_mv = MV_RIGHT;
        end

        // A repeat press of the bit being served re-arms it for the next cycle.
        w_move_nxt = w_stay_move ? w_sel_mv : MV_NONE;
        w_pend_nxt = w_stay_move ? ((w_req & ~w_sel) | (r_pend & w_btn & w_sel)) : 3'b000;

        if (!w_stay_move) begin
            w_drop_cnt_nxt = '0;
        end else if (r_drop_cnt == c_drop_last) begin
            w_drop_cnt_nxt = '0;
        end else begin
            w_drop_cnt_nxt = r_drop_cnt + 8'd1;
        end
        w_drop_nxt = (w_state_nxt == ST_MOVE) && (w_drop_cnt_nxt == c_drop_last);

        w_clr_cnt_nxt  = ((r_state == ST_CLEAR) && (w_state_nxt == ST_CLEAR)) ?
                         (r_clr_cnt + 1'b1) : '0;
        w_clear_en_nxt = (w_state_nxt == ST_CLEAR);
        w_load_nxt     = (w_state_nxt == ST_GEN) && !w_top_busy;
    end

`ifdef GAME_CTRL_SCORE_EN
    logic [CNT_W-1:0]   r_clear_cnt;
    logic [SCORE_W-1:0] r_score;

    always_ff @(posedge clka or negedge restart) begin
        if (!restart) begin
            r_clear_cnt <= '0;
            r_score     <= '0;
        end else begin
            if (r_state == ST_LAND) begin
                r_clear_cnt <= w_full_cnt;
            end
            if (w_state_nxt == ST_NEWBOARD) begin
                r_score <= '0;
            end else if ((r_state == ST_CLEAR) && (r_clr_cnt == '0)) begin
                r_score <= score_add_sat(r_score, r_clear_cnt);
            end
        end
    end

    assign score = r_score;
`else
    logic [CNT_W-1:0] w_unused_full_cnt;
    assign w_unused_full_cnt = w_full_cnt;
    assign score             = '0;
`endif

    assign state      = r_state;
    assign move       = r_move;
    assign drop       = r_drop;
    assign load_piece = r_load;
    assign clear_en   = r_clear_en;

endmodule

`default_nettype wire

// File: doc/game_ctrl.md
GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 Parameter DROP_TICKS, default 8: clka cycles in MOVE between gravity drop pulses, legal range 2..255.
REQ-002 Parameter CLEAR_CYCLES, default 2: cycles spent in CLEAR, legal range 1..15.
REQ-003 Port clka  in  1: single clock, all state updates on posedge.
REQ-004 Port restart  in  1: asynchronous, active-low reset.
REQ-005 Port start  in  1: one-cycle request to leave GAMEOVER.
REQ-006 Ports btn_left, btn_right, btn_rotate  in  1 each: one-cycle move requests.
REQ-007 Port touched  in  1: datapath reports that the piece has landed.
REQ-008 Port error  in  1: datapath reports an illegal redraw.
REQ-009 Port board_in  in  32: board as 8 rows of 4 bits; row k = bits [4k+3:4k]; row 7 is top.
REQ-010 Port state  out  3: GEN=0, MOVE=1, LAND=2, CLEAR=3, NEWBOARD=4, GAMEOVER=5.
REQ-011 Port move  out  2: 0=left, 1=right, 2=rotate, 3=none.
REQ-012 Port drop  out  1: one-cycle gravity pulse.
REQ-013 Port load_piece  out  1: one-cycle pulse, spawn a new piece.
REQ-014 Port clear_en  out  1: high throughout CLEAR.
REQ-015 Port score  out  16: count of rows cleared.

Function
REQ-016 All outputs shall be registered; state, move, drop, load_piece and clear_en shall change only on posedge clka or on reset.
REQ-017 NEWBOARD shall last 1 cycle, clear the score, and then go to GEN.
REQ-018 GEN shall last 1 cycle and go to GAMEOVER if board_in row 7 != 0; otherwise it shall pulse load_piece in that cycle and go to MOVE.
REQ-019 MOVE, button latching: a btn_* pulse shall set its pending bit.
REQ-020 MOVE, issue rule: each cycle, move shall show the highest-priority pending request (rotate > left > right) and clear only that bit; move shall be 3 when nothing is pending.
REQ-021 A new press arriving in the same cycle its pending bit is cleared shall re-set that bit.
REQ-022 Outside MOVE, button pulses shall be ignored and pending bits cleared.
REQ-023 The drop counter shall reset to 0 on entry to MOVE and increment every MOVE cycle.
REQ-024 When the drop counter reaches DROP_TICKS-1, drop shall pulse and the counter shall wrap to 0; drop may coincide with a move.
REQ-025 touched=1 in MOVE shall go to LAND next cycle; the move and drop outputs of that cycle shall still issue.
REQ-026 LAND shall last 1 cycle and go to CLEAR if any row == 4'hF, else to GEN.
REQ-027 LAND shall latch the number of full rows (0..8) into a clear count.
REQ-028 CLEAR shall hold clear_en=1 for exactly CLEAR_CYCLES cycles and then go to GEN.
REQ-029 On CLEAR entry, score shall add the latched clear count, saturating at 16'hFFFF.
REQ-030 GAMEOVER shall hold until start=1, then go to NEWBOARD.
REQ-031 error=1 in any state except GAMEOVER shall force GAMEOVER next cycle, overriding every other transition.
REQ-032 In GAMEOVER, move shall be 3 and drop, load_piece and clear_en shall be 0.
REQ-033 start shall be ignored outside GAMEOVER.

Reset
REQ-034 restart=0 shall immediately set state=NEWBOARD, move=3, drop=0, load_piece=0, clear_en=0, score=0, and clear the pending bits and all counters.
REQ-035 A reset asserted mid-MOVE or mid-CLEAR shall abandon the operation with no residual pulse after release.
REQ-036 The first posedge after restart rises shall execute NEWBOARD.

Configuration
REQ-037 Macro GAME_CTRL_SCORE_EN: when defined, the score counter and clear count shall be implemented per REQ-027/REQ-029.
REQ-038 When GAME_CTRL_SCORE_EN is undefined, score shall be tied to 0, no score or clear-count registers shall exist, and the CLEAR timing shall be unchanged.

Structure
REQ-039 A shared package tetris_pkg shall hold the state encodings, the move encodings (MV_LEFT, MV_RIGHT, MV_ROTATE, MV_NONE), ROWS=8 and ROW_W=4; the datapath shall use the same package.
REQ-040 One sub-module, row_full_count, shall be combinational: board_in to a full-row flag and a 4-bit count.

Verification
REQ-041 Release reset with board_in=0 -> state sequence 4,0,1 with load_piece=1 in the GEN cycle.
REQ-042 In MOVE, btn_left and btn_rotate in the same cycle -> move=2 next cycle, move=0 the cycle after, then move=3.
REQ-043 DROP_TICKS=8, 20 cycles in MOVE -> drop pulses in MOVE cycles 8 and 16 only.
REQ-044 touched in MOVE with board_in=32'h0000_F00F -> LAND, then CLEAR with clear_en high for 2 cycles, score=2, then GEN.
REQ-045 GEN with board_in=32'hF000_0000 -> GAMEOVER; hold start=0 for 10 cycles -> stays; start pulse -> NEWBOARD with score=0.
REQ-046 error pulse mid-CLEAR -> GAMEOVER next cycle and clear_en=0; restart low mid-MOVE -> state=4 with no clock edge.
